uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (1..16).
REQ-002 SHALL have parameter DATA_W, default 12, sample width per requester (1..12).
REQ-003 SHALL have parameter START_TIMEOUT, default 480, max cycles to wait for tx_busy rise after start_tx.
REQ-004 SHALL have port clk  in  1  single system clock, 48 MHz, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous active-low reset.
REQ-006 SHALL have port req  in  N_REQ  per-requester level request, held until its ack.
REQ-007 SHALL have port req_data  in  N_REQ*DATA_W  sample of requester i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port ack  out  N_REQ  one-cycle pulse when requester i's sample is latched.
REQ-009 SHALL have port start_tx  out  1  start strobe to uart_tx.
REQ-010 SHALL have port data_to_tx  out  8  byte to uart_tx.
REQ-011 SHALL have port tx_busy  in  1  busy flag from uart_tx.
REQ-012 SHALL have port frame_done  out  1  one-cycle pulse after the last byte of a frame completes.
REQ-013 SHALL have port timeout_err  out  1  one-cycle pulse when a frame is aborted.

Function
REQ-014 SHALL share one uart_tx among N_REQ requesters, sending one 4-byte frame per granted request.
REQ-015 Frame SHALL be: B0={4'hA, id[3:0]}, B1={4'h0, sample zero-extended [11:8]}, B2=sample[7:0], B3=B0^B1^B2.
REQ-016 States SHALL be IDLE, GRANT, LOAD, START, WAIT_DONE, NEXT.
REQ-017 IDLE: if any req bit set, go to GRANT next cycle; else stay.
REQ-018 GRANT: select round-robin winner starting at pointer ptr, latch id and sample, pulse ack[id] this cycle, go LOAD.
REQ-019 After grant to id, ptr SHALL become (id+1) mod N_REQ; ptr wraps from N_REQ-1 to 0.
REQ-020 LOAD: drive data_to_tx with current byte (index 0..3), go START.
REQ-021 START: hold start_tx=1 and data_to_tx stable until tx_busy observed high, then deassert start_tx and go WAIT_DONE.
REQ-022 START: if tx_busy not high within START_TIMEOUT cycles, deassert start_tx, pulse timeout_err, discard frame, go IDLE.
REQ-023 WAIT_DONE: wait for tx_busy low, then go NEXT.
REQ-024 NEXT: if byte index <3, increment, go LOAD; else pulse frame_done, go IDLE.
REQ-025 Request changes during a frame SHALL not affect the frame in flight; sample latched only in GRANT.
REQ-026 Requests deasserted before GRANT SHALL be ignored; no ack issued.
REQ-027 All N_REQ continuously requesting SHALL be served in order ptr, ptr+1, ... with no requester served twice before all others.
REQ-028 Minimum latency req-to-ack from IDLE SHALL be 2 cycles.

Reset
REQ-029 On reset low: state=IDLE, ptr=0, byte index=0, start_tx=0, data_to_tx=8'h00, ack=0, frame_done=0, timeout_err=0, timeout counter=0.
REQ-030 Reset mid-frame SHALL abort immediately with no frame_done or timeout_err; outputs take reset values asynchronously.

Structure
REQ-031 Frame header nibble 4'hA and state encodings SHALL live in the shared UART header alongside baud constants.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, ptr; outputs onehot grant, id).

Verification
REQ-033 Single req[2]=1, sample 12'h5C3 -> ack[2] 2 cycles later; bytes A2,05,C3,64 in order; one frame_done.
REQ-034 req=4'b1111 continuously, ptr=0 -> grants in order 0,1,2,3,0; ptr wraps to 0 after id 3.
REQ-035 tx_busy held low by model -> after 480 cycles in START: timeout_err pulse, start_tx low, state IDLE, no frame_done.
REQ-036 Reset asserted during WAIT_DONE of byte 1 -> start_tx=0 immediately; after release, new req[0] starts a fresh frame at B0.
REQ-037 req_data[1] changed during frame 1 -> transmitted bytes match value latched at ack, not new value.
REQ-038 req[3] pulsed 1 cycle while another frame in flight and then deasserted -> no ack[3], no frame for id 3.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared UART definitions: baud constants, frame header and scheduler state encodings.
package uart_tx_sched_pkg;

    // Baud constants for the 48 MHz system clock
    localparam int CLK_FREQ_HZ = 48_000_000;
    localparam int BAUD_RATE   = 115_200;
    localparam int BAUD_DIV    = CLK_FREQ_HZ / BAUD_RATE;

    // Frame layout
    localparam logic [3:0] FRAME_HDR   = 4'hA;
    localparam int         FRAME_BYTES = 4;
    localparam int         SAMPLE_W    = 12;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        LOAD,
        START,
        WAIT_DONE,
        NEXT
    } sched_state_t;

    // Byte idx of the frame for requester id carrying a 12-bit sample.
    // Byte 3 is a plain XOR checksum over bytes 0..2.
    function automatic logic [7:0] frame_byte(
        input logic [3:0]  id,
        input logic [11:0] sample,
        input logic [1:0]  idx
    );
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        b0 = {FRAME_HDR, id};
        b1 = {4'h0, sample[11:8]};
        b2 = sample[7:0];
        case (idx)
            2'd0:    frame_byte = b0;
            2'd1:    frame_byte = b1;
            2'd2:    frame_byte = b2;
            default: frame_byte = b0 ^ b1 ^ b2;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after ptr, wrapping.
module rr_arbiter
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [3:0]       ptr,
    output logic [N_REQ-1:0] grant,
    output logic [3:0]       id
);

    // Scan from ptr upward modulo N_REQ; the first hit wins
    always_comb begin
        int   cand;
        logic found;
        grant = '0;
        id    = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                id          = 4'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Schedules fixed 4-byte frames from N_REQ requesters onto a single uart_tx.
// Each granted request is latched once, then its bytes are handed to the
// transmitter one at a time with a start/busy handshake.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int DATA_W        = 12,
    parameter int START_TIMEOUT = 480
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    output logic                    start_tx,
    output logic [7:0]              data_to_tx,
    input  logic                    tx_busy,
    output logic                    frame_done,
    output logic                    timeout_err
);

    localparam int               TMR_W    = $clog2(START_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(START_TIMEOUT - 1);
    localparam logic [3:0]       ID_LAST  = 4'(N_REQ - 1);

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [3:0]        ptr;
    logic [3:0]        ptr_nxt;
    logic [1:0]        byte_idx;
    logic [1:0]        byte_idx_nxt;
    logic [3:0]        cur_id;
    logic [3:0]        cur_id_nxt;
    logic [11:0]       cur_sample;
    logic [11:0]       cur_sample_nxt;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_nxt;
    logic              start_nxt;
    logic [7:0]        data_nxt;
    logic [N_REQ-1:0]  ack_nxt;
    logic              done_nxt;
    logic              tmo_nxt;

    logic [N_REQ-1:0]  arb_grant;
    logic [3:0]        arb_id;
    logic [DATA_W-1:0] arb_sample;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .id    (arb_id)
    );

    assign arb_sample = req_data[int'(arb_id)*DATA_W +: DATA_W];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output logic; outputs are registered below so they never glitch
    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        byte_idx_nxt   = byte_idx;
        cur_id_nxt     = cur_id;
        cur_sample_nxt = cur_sample;
        timer_nxt      = timer;
        start_nxt      = start_tx;
        data_nxt       = data_to_tx;
        ack_nxt        = '0;
        done_nxt       = 1'b0;
        tmo_nxt        = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = GRANT;
                end
            end

            GRANT: begin
                // A request that vanished since IDLE gets no ack and no frame
                if (|arb_grant) begin
                    cur_id_nxt     = arb_id;
                    cur_sample_nxt = 12'(arb_sample);
                    ack_nxt        = arb_grant;
                    ptr_nxt        = (arb_id == ID_LAST) ? 4'd0 : arb_id + 4'd1;
                    byte_idx_nxt   = 2'd0;
                    state_nxt      = LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end

            LOAD: begin
                data_nxt  = frame_byte(cur_id, cur_sample, byte_idx);
                start_nxt = 1'b1;
                timer_nxt = '0;
                state_nxt = START;
            end

            START: begin
                if (tx_busy) begin
                    start_nxt = 1'b0;
                    state_nxt = WAIT_DONE;
                end else if (timer == TMR_LAST) begin
                    start_nxt    = 1'b0;
                    tmo_nxt      = 1'b1;
                    byte_idx_nxt = 2'd0;
                    state_nxt    = IDLE;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end

            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt = NEXT;
                end
            end

            NEXT: begin
                if (byte_idx != 2'd3) begin
                    byte_idx_nxt = byte_idx + 2'd1;
                    state_nxt    = LOAD;
                end else begin
                    byte_idx_nxt = 2'd0;
                    done_nxt     = 1'b1;
                    state_nxt    = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and output registers; reset clears every output asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr         <= '0;
            byte_idx    <= '0;
            cur_id      <= '0;
            cur_sample  <= '0;
            timer       <= '0;
            start_tx    <= 1'b0;
            data_to_tx  <= 8'h00;
            ack         <= '0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ptr         <= ptr_nxt;
            byte_idx    <= byte_idx_nxt;
            cur_id      <= cur_id_nxt;
            cur_sample  <= cur_sample_nxt;
            timer       <= timer_nxt;
            start_tx    <= start_nxt;
            data_to_tx  <= data_nxt;
            ack         <= ack_nxt;
            frame_done  <= done_nxt;
            timeout_err <= tmo_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: directed scenarios with random samples and
// request masks, checked against a frame/round-robin reference model.
module tb_uart_tx_sched;

    localparam int N_REQ         = 4;
    localparam int DATA_W        = 12;
    localparam int START_TIMEOUT = 480;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        ack;
    logic                    start_tx;
    logic [7:0]              data_to_tx;
    logic                    tx_busy = 1'b0;
    logic                    frame_done;
    logic                    timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]       byte_q[$];
    logic [N_REQ-1:0] ack_q[$];
    int               fd_count = 0;
    int               to_count = 0;
    bit               uart_en  = 1'b1;

    uart_tx_sched #(
        .N_REQ         (N_REQ),
        .DATA_W        (DATA_W),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .start_tx    (start_tx),
        .data_to_tx  (data_to_tx),
        .tx_busy     (tx_busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    // Free-running clock
    always #10 clk = ~clk;

    // Event monitor sampling registered outputs just after each rising edge
    always @(posedge clk) begin
        #1;
        if (ack != '0) ack_q.push_back(ack);
        if (frame_done === 1'b1) fd_count++;
        if (timeout_err === 1'b1) to_count++;
    end

    // Transmitter model: accepts a start after a random delay, stays busy a random time
    always begin
        @(negedge clk);
        if (uart_en && start_tx === 1'b1 && tx_busy === 1'b0) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            byte_q.push_back(data_to_tx);
            tx_busy = 1'b1;
            repeat ($urandom_range(3, 6)) @(negedge clk);
            tx_busy = 1'b0;
        end
    end

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] exp_byte(input int id, input int sample, input int k);
        int b0;
        int b1;
        int b2;
        b0 = 'hA0 + id;
        b1 = sample / 256;
        b2 = sample % 256;
        case (k)
            0:       return 8'(b0);
            1:       return 8'(b1);
            2:       return 8'(b2);
            default: return 8'(b0 ^ b1 ^ b2);
        endcase
    endfunction

    function automatic int rr_next(input int p, input logic [N_REQ-1:0] m);
        for (int off = 0; off < N_REQ; off++) begin
            if (m[(p + off) % N_REQ]) return (p + off) % N_REQ;
        end
        return -1;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_sample(input int id, input int sample);
        req_data[id*DATA_W +: DATA_W] = DATA_W'(sample);
    endtask

    task automatic wait_acks(input int target, input int budget);
        int n;
        n = 0;
        while (ack_q.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (ack_q.size() < target) check_output("ack_wait", 32'(ack_q.size()), 32'(target));
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (fd_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (fd_count < target) check_output("frame_wait", 32'(fd_count), 32'(target));
    endtask

    task automatic check_frame(input string tag, input int id, input int sample);
        logic [31:0] obs;
        for (int k = 0; k < 4; k++) begin
            obs = (byte_q.size() > 0) ? 32'(byte_q.pop_front()) : 32'hFFFF_FFFF;
            check_output(tag, obs, 32'(exp_byte(id, sample, k)));
        end
    endtask

    // One single-requester frame; new_sample >= 0 rewrites the input right after ack
    task automatic apply_stimulus(input int id, input int sample, input int new_sample);
        int               fd_base;
        logic [N_REQ-1:0] got;
        set_sample(id, sample);
        ack_q.delete();
        byte_q.delete();
        fd_base = fd_count;
        @(negedge clk);
        req[id] = 1'b1;
        wait_acks(1, 20);
        got = (ack_q.size() > 0) ? ack_q.pop_front() : '0;
        check_output("single_ack", 32'(got), 32'(1 << id));
        req[id] = 1'b0;
        if (new_sample >= 0) set_sample(id, new_sample);
        wait_frames(fd_base + 1, 400);
        check_frame("single_frame", id, sample);
    endtask

    initial begin
        int               samples[N_REQ];
        int               exp_ids[$];
        int               model_ptr;
        int               fd_base;
        int               to_base;
        int               hi;
        int               n;
        int               s1;
        logic [N_REQ-1:0] mask;
        logic [N_REQ-1:0] got;

        reset    = 1'b0;
        req      = '0;
        req_data = '0;
        repeat (3) @(negedge clk);
        check_output("rst_start_tx", 32'(start_tx), 32'd0);
        check_output("rst_data", 32'(data_to_tx), 32'd0);
        check_output("rst_ack", 32'(ack), 32'd0);
        check_output("rst_frame_done", 32'(frame_done), 32'd0);
        check_output("rst_timeout", 32'(timeout_err), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // All requesters held: grants 0,1,2,3 then wrap to 0
        for (int i = 0; i < N_REQ; i++) begin
            samples[i] = int'($urandom_range(0, 4095));
            set_sample(i, samples[i]);
        end
        ack_q.delete();
        byte_q.delete();
        fd_base = fd_count;
        req = '1;
        wait_acks(5, 600);
        req = '0;
        wait_frames(fd_base + 5, 400);
        for (int k = 0; k < 5; k++) begin
            check_output("rr_order", (k < ack_q.size()) ? 32'(ack_q[k]) : 32'd0, 32'(1 << (k % N_REQ)));
            check_frame("rr_frame", k % N_REQ, samples[k % N_REQ]);
        end
        model_ptr = 1;

        // Random held mask: order follows the pointer model
        mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
        for (int i = 0; i < N_REQ; i++) begin
            samples[i] = int'($urandom_range(0, 4095));
            set_sample(i, samples[i]);
        end
        exp_ids.delete();
        for (int k = 0; k < 4; k++) begin
            exp_ids.push_back(rr_next(model_ptr, mask));
            model_ptr = (exp_ids[k] + 1) % N_REQ;
        end
        ack_q.delete();
        byte_q.delete();
        fd_base = fd_count;
        @(negedge clk);
        req = mask;
        wait_acks(4, 500);
        req = '0;
        wait_frames(fd_base + 4, 400);
        for (int k = 0; k < 4; k++) begin
            check_output("mask_order", (k < ack_q.size()) ? 32'(ack_q[k]) : 32'd0, 32'(1 << exp_ids[k]));
            check_frame("mask_frame", exp_ids[k], samples[exp_ids[k]]);
        end

        // Single req[2] with sample 5C3: ack two cycles later, fixed byte sequence
        set_sample(2, 'h5C3);
        ack_q.delete();
        byte_q.delete();
        fd_base = fd_count;
        @(negedge clk);
        req[2] = 1'b1;
        @(negedge clk);
        check_output("lat_cycle1", 32'(ack), 32'd0);
        @(negedge clk);
        check_output("lat_cycle2", 32'(ack), 32'h4);
        req[2] = 1'b0;
        wait_frames(fd_base + 1, 400);
        repeat (20) @(negedge clk);
        check_output("b0", (byte_q.size() > 0) ? 32'(byte_q.pop_front()) : 32'hFFFF, 32'hA2);
        check_output("b1", (byte_q.size() > 0) ? 32'(byte_q.pop_front()) : 32'hFFFF, 32'h05);
        check_output("b2", (byte_q.size() > 0) ? 32'(byte_q.pop_front()) : 32'hFFFF, 32'hC3);
        check_output("b3", (byte_q.size() > 0) ? 32'(byte_q.pop_front()) : 32'hFFFF, 32'h64);
        check_output("one_frame_done", 32'(fd_count - fd_base), 32'd1);

        // Random single frames
        for (int r = 0; r < 4; r++) begin
            apply_stimulus(int'($urandom_range(0, N_REQ - 1)), int'($urandom_range(0, 4095)), -1);
        end

        // Sample changed after ack must not leak into the frame
        s1 = int'($urandom_range(0, 4095));
        apply_stimulus(1, s1, s1 ^ 'hFFF);

        // One-cycle req[3] pulse during a frame is ignored
        set_sample(3, int'($urandom_range(0, 4095)));
        s1 = int'($urandom_range(0, 4095));
        set_sample(0, s1);
        ack_q.delete();
        byte_q.delete();
        fd_base = fd_count;
        @(negedge clk);
        req[0] = 1'b1;
        wait_acks(1, 20);
        got = (ack_q.size() > 0) ? ack_q.pop_front() : '0;
        check_output("pulse_ack0", 32'(got), 32'h1);
        req[0] = 1'b0;
        req[3] = 1'b1;
        @(negedge clk);
        req[3] = 1'b0;
        wait_frames(fd_base + 1, 400);
        repeat (30) @(negedge clk);
        check_frame("pulse_frame", 0, s1);
        check_output("pulse_no_ack3", 32'(ack_q.size()), 32'd0);
        check_output("pulse_frames", 32'(fd_count - fd_base), 32'd1);

        // Transmitter never goes busy: start held START_TIMEOUT cycles then abort
        uart_en = 1'b0;
        ack_q.delete();
        byte_q.delete();
        fd_base = fd_count;
        to_base = to_count;
        set_sample(1, int'($urandom_range(0, 4095)));
        @(negedge clk);
        req[1] = 1'b1;
        wait_acks(1, 20);
        req[1] = 1'b0;
        n = 0;
        while (start_tx !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        hi = 0;
        while (start_tx === 1'b1 && hi < 1000) begin
            hi++;
            @(negedge clk);
        end
        check_output("tmo_start_cycles", 32'(hi), 32'(START_TIMEOUT));
        check_output("tmo_pulse", 32'(timeout_err), 32'd1);
        check_output("tmo_count", 32'(to_count - to_base), 32'd1);
        repeat (20) @(negedge clk);
        check_output("tmo_start_low", 32'(start_tx), 32'd0);
        check_output("tmo_no_done", 32'(fd_count - fd_base), 32'd0);
        check_output("tmo_single_pulse", 32'(to_count - to_base), 32'd1);
        uart_en = 1'b1;
        apply_stimulus(3, int'($urandom_range(0, 4095)), -1);

        // Reset during WAIT_DONE of byte 1, then a fresh frame
        ack_q.delete();
        byte_q.delete();
        fd_base = fd_count;
        to_base = to_count;
        set_sample(2, 'hF3C);
        @(negedge clk);
        req[2] = 1'b1;
        wait_acks(1, 20);
        req[2] = 1'b0;
        n = 0;
        while (byte_q.size() < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_output("rst_mid_bytes", 32'(byte_q.size()), 32'd2);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("rst_mid_start", 32'(start_tx), 32'd0);
        check_output("rst_mid_data", 32'(data_to_tx), 32'd0);
        repeat (3) @(negedge clk);
        check_output("rst_mid_no_done", 32'(fd_count - fd_base), 32'd0);
        check_output("rst_mid_no_tmo", 32'(to_count - to_base), 32'd0);
        reset = 1'b1;
        n = 0;
        while (tx_busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        apply_stimulus(0, int'($urandom_range(0, 4095)), -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
